// File: rtl/pwm_audio_out.sv
// PWM audio output stage: scales the mixer sample about midscale by a click-free mute/unmute gain ramp.
// One 256-clock PWM period per sample; duty, gain and FSM update only on the cnt==255 boundary cycle.
module pwm_audio_out #(
  parameter int RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       enable,
  output logic       pwm_out,
  output logic       sample_tick,
  output logic [8:0] gain,
  output logic [1:0] state,
  output logic       muted
);

  localparam logic [1:0] ST_MUTED     = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_PLAY      = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  localparam logic [9:0] STEP  = 10'(RAMP_STEP);
  localparam logic [9:0] UNITY = 10'd256;

  logic [7:0]         r_cnt;
  logic [7:0]         r_duty;
  logic [8:0]         r_gain;
  logic [1:0]         r_state;
  logic               r_pwm;
  logic               r_tick;
  logic               r_muted;

  logic               w_boundary;
  logic signed [8:0]  w_s;
  logic signed [18:0] w_prod;
  logic [7:0]         w_duty;
  logic [9:0]         w_gain_ext;
  logic [9:0]         w_up;
  logic [8:0]         w_gain_nxt;
  logic [1:0]         w_state_nxt;
  logic               w_unused;

  assign w_boundary = (r_cnt == 8'hFF);

  // Product bits [15:8] are p>>>8 modulo 256; the +128 result always lands in 0..255.
  assign w_s        = $signed({1'b0, sample_in}) - 9'sd128;
  assign w_prod     = 19'(w_s) * 19'($signed({1'b0, r_gain}));
  assign w_duty     = w_prod[15:8] + 8'd128;
  assign w_unused   = ^{w_prod[18:16], w_prod[7:0]};

  assign w_gain_ext = {1'b0, r_gain};
  assign w_up       = w_gain_ext + STEP;

  always_comb begin
    w_gain_nxt  = r_gain;
    w_state_nxt = r_state;
    case (r_state)
      ST_MUTED: begin
        w_gain_nxt = 9'd0;
        if (enable) w_state_nxt = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (enable) begin
          if (w_up >= UNITY) begin
            w_gain_nxt  = 9'd256;
            w_state_nxt = ST_PLAY;
          end else begin
            w_gain_nxt  = w_up[8:0];
          end
        end else begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_PLAY: begin
        w_gain_nxt = 9'd256;
        if (!enable) w_state_nxt = ST_RAMP_DOWN;
      end
      default: begin
        if (!enable) begin
          if (w_gain_ext <= STEP) begin
            w_gain_nxt  = 9'd0;
            w_state_nxt = ST_MUTED;
          end else begin
            w_gain_nxt  = 9'(w_gain_ext - STEP);
          end
        end else begin
          w_state_nxt = ST_RAMP_UP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_duty  <= 8'd128;
      r_gain  <= 9'd0;
      r_state <= ST_MUTED;
      r_pwm   <= 1'b0;
      r_tick  <= 1'b0;
      r_muted <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
      r_tick <= w_boundary;
      r_pwm  <= (r_cnt < r_duty);
      if (w_boundary) begin
        r_duty  <= w_duty;
        r_gain  <= w_gain_nxt;
        r_state <= w_state_nxt;
        r_muted <= (w_state_nxt == ST_MUTED);
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign sample_tick = r_tick;
  assign gain        = r_gain;
  assign state       = r_state;
  assign muted       = r_muted;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: two instances (RAMP_STEP 4 and 128) share stimulus; a per-boundary
// model pushes expected gain/state/duty, compared one period later against registers and PWM high count.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample_in = 8'd128;

  logic       pwm4, tick4, mt4;
  logic [8:0] gain4;
  logic [1:0] st4;
  logic       pwm128, tick128, mt128;
  logic [8:0] gain128;
  logic [1:0] st128;

  pwm_audio_out #(.RAMP_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .enable(enable),
    .pwm_out(pwm4), .sample_tick(tick4), .gain(gain4), .state(st4), .muted(mt4)
  );

  pwm_audio_out #(.RAMP_STEP(128)) dut128 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .enable(enable),
    .pwm_out(pwm128), .sample_tick(tick128), .gain(gain128), .state(st128), .muted(mt128)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] gain;
    logic [1:0] st;
    logic       mt;
    logic [8:0] hi;
    logic       tk;
  } rec_t;

  rec_t q4[$];
  rec_t q128[$];
  int   m_gain [2];
  int   m_st   [2];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic string fmt(input rec_t r);
    return $sformatf("gain=%0d state=%0d muted=%0d high=%0d tick=%0d", r.gain, r.st, r.mt, r.hi, r.tk);
  endfunction

  task automatic model_reset();
    m_gain = '{0, 0};
    m_st   = '{0, 0};
    q4.delete();
    q128.delete();
  endtask

  // Expected outcome of one boundary: duty from the pre-update gain, then the FSM/gain step.
  task automatic model_push(input logic en, input logic [7:0] smp);
    rec_t r;
    int s, p, g, st, stp;
    for (int d = 0; d < 2; d++) begin
      stp = (d == 0) ? 4 : 128;
      s   = int'(smp) - 128;
      p   = s * m_gain[d];
      g   = m_gain[d];
      st  = m_st[d];
      case (st)
        0: begin g = 0; if (en) st = 1; end
        1: if (en) begin g = g + stp; if (g >= 256) begin g = 256; st = 2; end end
           else st = 3;
        2: begin g = 256; if (!en) st = 3; end
        default: if (!en) begin g = g - stp; if (g <= 0) begin g = 0; st = 0; end end
                 else st = 1;
      endcase
      m_gain[d] = g;
      m_st[d]   = st;
      r.gain = 9'(g);
      r.st   = 2'(st);
      r.mt   = (st == 0);
      r.hi   = 9'(128 + (p >>> 8));
      r.tk   = 1'b1;
      if (d == 0) q4.push_back(r);
      else        q128.push_back(r);
    end
  endtask

  // Entered at the negedge of a tick cycle: captures registers, drives the next boundary's inputs
  // (optionally glitching them mid-period), counts PWM highs, and returns at the next tick cycle.
  task automatic run_period(input logic en, input logic [7:0] smp, input bit glitch,
                            output rec_t o4, output rec_t o128);
    logic [8:0] h4, h128;
    h4 = 9'd0;
    h128 = 9'd0;
    o4.gain = gain4;     o4.st = st4;     o4.mt = mt4;     o4.tk = tick4;
    o128.gain = gain128; o128.st = st128; o128.mt = mt128; o128.tk = tick128;
    enable = en;
    sample_in = smp;
    model_push(en, smp);
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      h4   = h4 + 9'(pwm4);
      h128 = h128 + 9'(pwm128);
      if (glitch && i == 100) begin enable = ~en; sample_in = ~smp; end
      if (glitch && i == 200) begin enable = en;  sample_in = smp;  end
    end
    o4.hi = h4;
    o128.hi = h128;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    logic [8:0] h;
    reset = 1'b1; enable = 1'b1; sample_in = 8'd200;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pwm4, gain4, st4, mt4, tick4} !== {1'b0, 9'd0, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset4 got pwm/gain/state/muted/tick=%0d/%0d/%0d/%0d/%0d required 0/0/0/1/0", pwm4, gain4, st4, mt4, tick4);
    end
    vectors++;
    if ({pwm128, gain128, st128, mt128, tick128} !== {1'b0, 9'd0, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset128 got pwm/gain/state/muted/tick=%0d/%0d/%0d/%0d/%0d required 0/0/0/1/0", pwm128, gain128, st128, mt128, tick128);
    end
    reset = 1'b0; enable = 1'b0; sample_in = 8'd255;
    model_reset();
    model_push(1'b0, 8'd255);
    n = 0; h = 9'd0;
    while (tick4 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (n <= 255) h = h + 9'(pwm4);
    end
    vectors++;
    if (n !== 256 || tick128 !== 1'b1) begin
      miscompares++;
      $display("FAIL first_tick got %0d clocks (tick128=%0d) required 256", n, tick128);
    end
    vectors++;
    if (h !== 9'd128) begin
      miscompares++;
      $display("FAIL reset_duty got %0d high clocks required 128", h);
    end
  endtask

  task automatic test_muted();
    rec_t o4, o128, e4, e128;
    for (int k = 0; k < 4; k++) begin
      run_period(1'b0, 8'd255, 1'b1, o4, o128);
      e4 = q4.pop_front(); e128 = q128.pop_front();
      vectors += 3;
      if (o4 !== e4) begin miscompares++; $display("FAIL muted4 k=%0d got %s required %s", k, fmt(o4), fmt(e4)); end
      if (o128 !== e128) begin miscompares++; $display("FAIL muted128 k=%0d got %s required %s", k, fmt(o128), fmt(e128)); end
      if (o4.hi !== 9'd128 || o4.st !== 2'd0) begin
        miscompares++; $display("FAIL muted_silence k=%0d got high=%0d state=%0d required 128/0", k, o4.hi, o4.st);
      end
    end
  endtask

  task automatic test_ramp_up();
    rec_t o4, o128, e4, e128;
    for (int k = 0; k <= 68; k++) begin
      run_period(1'b1, (k >= 67) ? 8'd0 : 8'd255, 1'b0, o4, o128);
      e4 = q4.pop_front(); e128 = q128.pop_front();
      vectors += 2;
      if (o4 !== e4) begin miscompares++; $display("FAIL ramp4 k=%0d got %s required %s", k, fmt(o4), fmt(e4)); end
      if (o128 !== e128) begin miscompares++; $display("FAIL ramp128 k=%0d got %s required %s", k, fmt(o128), fmt(e128)); end
      if (k == 1) begin
        vectors++;
        if (o4.st !== 2'd1 || o4.gain !== 9'd0) begin miscompares++; $display("FAIL ramp_start got state=%0d gain=%0d required 1/0", o4.st, o4.gain); end
      end
      if (k == 65) begin
        vectors++;
        if (o4.st !== 2'd2 || o4.gain !== 9'd256) begin miscompares++; $display("FAIL ramp_play got state=%0d gain=%0d required 2/256", o4.st, o4.gain); end
      end
      if (k == 66) begin
        vectors++;
        if (o4.hi !== 9'd255) begin miscompares++; $display("FAIL play_full got high=%0d required 255", o4.hi); end
      end
      if (k == 68) begin
        vectors++;
        if (o4.hi !== 9'd0) begin miscompares++; $display("FAIL play_zero got high=%0d required 0", o4.hi); end
      end
    end
  endtask

  task automatic test_reset_mid_play();
    int n;
    logic [8:0] h;
    vectors++;
    if (st4 !== 2'd2 || gain4 !== 9'd256) begin miscompares++; $display("FAIL pre_reset got state=%0d gain=%0d required 2/256", st4, gain4); end
    repeat (77) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pwm4, gain4, st4, mt4, tick4} !== {1'b0, 9'd0, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset got pwm/gain/state/muted/tick=%0d/%0d/%0d/%0d/%0d required 0/0/0/1/0", pwm4, gain4, st4, mt4, tick4);
    end
    reset = 1'b0; enable = 1'b0; sample_in = 8'd200;
    model_reset();
    model_push(1'b0, 8'd200);
    n = 0; h = 9'd0;
    while (tick4 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (n <= 255) h = h + 9'(pwm4);
    end
    vectors++;
    if (n !== 256 || h !== 9'd128) begin
      miscompares++; $display("FAIL mid_reset_restart got tick after %0d high=%0d required 256/128", n, h);
    end
  endtask

  task automatic test_reversal();
    rec_t o4, o128, e4, e128;
    logic en_seq[$];
    for (int i = 0; i < 26; i++) en_seq.push_back(1'b1);
    for (int i = 0; i < 27; i++) en_seq.push_back(1'b0);
    for (int i = 0; i < 26; i++) en_seq.push_back(1'b1);
    for (int i = 0; i < 14; i++) en_seq.push_back(1'b0);
    for (int i = 0; i < 3;  i++) en_seq.push_back(1'b1);
    for (int k = 0; k < en_seq.size(); k++) begin
      run_period(en_seq[k], 8'd200, 1'b1, o4, o128);
      e4 = q4.pop_front(); e128 = q128.pop_front();
      vectors += 2;
      if (o4 !== e4) begin miscompares++; $display("FAIL rev4 k=%0d got %s required %s", k, fmt(o4), fmt(e4)); end
      if (o128 !== e128) begin miscompares++; $display("FAIL rev128 k=%0d got %s required %s", k, fmt(o128), fmt(e128)); end
      if (k == 27) begin
        vectors++;
        if (o4.st !== 2'd3 || o4.gain !== 9'd100) begin miscompares++; $display("FAIL rev_down got state=%0d gain=%0d required 3/100", o4.st, o4.gain); end
      end
      if (k == 51 || k == 52) begin
        vectors++;
        if (o4.st !== ((k == 52) ? 2'd0 : 2'd3) || o4.gain !== ((k == 52) ? 9'd0 : 9'd4) || o4.mt !== (k == 52)) begin
          miscompares++; $display("FAIL rev_muted k=%0d got state=%0d gain=%0d muted=%0d", k, o4.st, o4.gain, o4.mt);
        end
      end
      if (k == 94 || k == 95) begin
        vectors++;
        if (o4.st !== 2'd1 || o4.gain !== ((k == 94) ? 9'd48 : 9'd52)) begin
          miscompares++; $display("FAIL rev_up k=%0d got state=%0d gain=%0d required 1/%0d", k, o4.st, o4.gain, (k == 94) ? 48 : 52);
        end
      end
    end
  endtask

  task automatic test_arith();
    rec_t o4, o128, e4, e128;
    logic [7:0] smp [5];
    logic [8:0] req [4];
    logic       en;
    smp = '{8'd0, 8'd255, 8'd129, 8'd127, 8'd128};
    req = '{9'd64, 9'd191, 9'd128, 9'd127};
    for (int k = 0; k < 40; k++) begin
      if (m_st[1] == 1 && m_gain[1] == 128) break;
      en = (k >= 4 && m_st[1] == 0) || (m_st[1] == 1);
      if (k < 4 && m_st[1] != 0) en = 1'b0;
      run_period(en, 8'd60, 1'b1, o4, o128);
      e4 = q4.pop_front(); e128 = q128.pop_front();
      vectors += 2;
      if (o4 !== e4) begin miscompares++; $display("FAIL arith_setup4 k=%0d got %s required %s", k, fmt(o4), fmt(e4)); end
      if (o128 !== e128) begin miscompares++; $display("FAIL arith_setup128 k=%0d got %s required %s", k, fmt(o128), fmt(e128)); end
    end
    // Alternating enable parks the step-128 instance at gain 128 (RAMP_UP <-> RAMP_DOWN).
    for (int k = 0; k < 5; k++) begin
      run_period(k[0], smp[k], 1'b1, o4, o128);
      e4 = q4.pop_front(); e128 = q128.pop_front();
      vectors += 2;
      if (o4 !== e4) begin miscompares++; $display("FAIL arith4 k=%0d got %s required %s", k, fmt(o4), fmt(e4)); end
      if (o128 !== e128) begin miscompares++; $display("FAIL arith128 k=%0d got %s required %s", k, fmt(o128), fmt(e128)); end
      if (k > 0) begin
        vectors++;
        if (o128.hi !== req[k-1] || o128.gain !== 9'd128) begin
          miscompares++; $display("FAIL arith_duty sample=%0d got duty=%0d gain=%0d required %0d/128", smp[k-1], o128.hi, o128.gain, req[k-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_muted();
    test_ramp_up();
    test_reset_mid_play();
    test_reversal();
    test_arith();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
